// File: rtl/shift_seq_ctrl_if.sv
// Load handshake between a parallel producer and shift_seq_ctrl.
// The producer holds Load_Data stable while Load_Valid is high and Load_Ready is low.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             Load_Valid;
    logic [WIDTH-1:0] Load_Data;
    logic             Load_Ready;

    modport master (
        output Load_Valid,
        output Load_Data,
        input  Load_Ready
    );

    modport slave (
        input  Load_Valid,
        input  Load_Data,
        output Load_Ready
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Serialises a handshaken word into a shift register, then captures its Q.
// Optional macro SHIFT_SEQ_LOOPBACK_CHECK_EN adds a loopback compare on Mismatch.
module shift_seq_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    shift_seq_ctrl_if.slave  load,
    output logic             Shift_En,
    output logic             D,
    input  logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Mismatch
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    idx;
    logic             last;

    assign last = (cnt == CW'(WIDTH - 1));

    // Frame sequencing: accept a word, shift WIDTH times, capture Q once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            hold   <= '0;
            Result <= '0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load.Load_Valid) begin
                        hold  <= load.Load_Data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CAPTURE: begin
                    Result <= Q;
                    Done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is masked by reset so the producer never sees a grant while held.
    assign load.Load_Ready = Rst_n && (state == IDLE);
    assign Shift_En        = (state == SHIFT);
    assign Busy            = (state == SHIFT) || (state == CAPTURE);

    // Bit select walks down from the MSB or up from the LSB.
    assign idx = MSB_FIRST ? (CW'(WIDTH - 1) - cnt) : cnt;
    assign D   = (state == SHIFT) ? hold[idx] : 1'b0;

`ifdef SHIFT_SEQ_LOOPBACK_CHECK_EN
    logic [WIDTH-1:0] expect_q;

    // What a healthy register must show after a full frame.
    always_comb begin
        expect_q = hold;
        if (!MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                expect_q[i] = hold[WIDTH-1-i];
            end
        end
    end

    // Compare pulse lines up with Done.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Mismatch <= 1'b0;
        end else begin
            Mismatch <= (state == CAPTURE) && (Q != expect_q);
        end
    end
`else
    assign Mismatch = 1'b0;
`endif

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencing controller for the serial-in shift-register datapath (D input, parallel Q output). It accepts a parallel word through a valid/ready handshake and drives it bit-serially into the shift register. Shifting is gated with an enable so the register holds between frames. After WIDTH shifts it captures the register's parallel output and pulses Done. It sits between a parallel producer and the shift register, and is the only driver of the register's D and enable.

Parameters:
WIDTH, 4, word width; also the number of shifts per frame (>=2).
MSB_FIRST, 1, 1 = transmit Load_Data[WIDTH-1] first; 0 = transmit Load_Data[0] first.

Ports:
Clk  input  1  rising-edge clock.
Rst_n  input  1  asynchronous, active-low reset.
Load_Valid  input  1  producer offers Load_Data.
Load_Data  input  WIDTH  word to serialise.
Load_Ready  output  1  controller can accept a word.
Shift_En  output  1  enable to the shift register; it shifts on the Clk edge when this is 1.
D  output  1  serial bit to the shift register's D input.
Q  input  WIDTH  shift register parallel output. Q[0] takes D; Q[i] takes Q[i-1].
Busy  output  1  frame in progress.
Done  output  1  one-cycle pulse when Result is updated.
Result  output  WIDTH  Q captured at end of frame.
Mismatch  output  1  loopback check result (see Optional Feature).

Behaviour:
- Reset (Rst_n low, asynchronous):
  - state=IDLE, bit counter=0, hold register=0, Result=0, Done=0, Mismatch=0.
  - Load_Ready=0, Shift_En=0, D=0, Busy=0 while Rst_n is low.
- States: IDLE, SHIFT, CAPTURE.
- IDLE:
  - Load_Ready=1, Shift_En=0, D=0, Busy=0.
  - Handshake = Load_Valid & Load_Ready at a rising edge (call it E0): latch Load_Data into the hold register, counter=0, go to SHIFT.
  - Load_Valid without Load_Ready is ignored; the producer holds data until accepted.
- SHIFT:
  - Shift_En=1, Busy=1, Load_Ready=0.
  - D = hold[WIDTH-1-cnt] when MSB_FIRST=1, else hold[cnt]. D is combinational from the hold register and counter, stable for the whole cycle.
  - Counter increments each edge.
  - On the edge where cnt==WIDTH-1, go to CAPTURE. The state therefore lasts exactly WIDTH cycles, with shift edges E1..EW.
- CAPTURE:
  - Shift_En=0, D=0, Busy=1, Load_Ready=0.
  - At edge E(W+1): Result<=Q, Done<=1, go to IDLE.
- Done:
  - Registered; high for exactly the one cycle between E(W+1) and E(W+2), then cleared.
  - Result holds its value until the next capture.
- Latency and throughput:
  - Result is valid W+1 edges after the handshake edge.
  - Load_Ready is low for exactly W+1 cycles per frame.
  - Load_Ready returns to 1 in the same cycle Done is high, so the next handshake can occur at E(W+2). Back-to-back frames take W+2 cycles each.
- Expected Result for a correct shift register:
  - MSB_FIRST=1: Result==Load_Data.
  - MSB_FIRST=0: Result==bit-reverse(Load_Data).
- Boundary conditions:
  - Load_Valid held high continuously: no word is accepted while Busy; exactly one word is accepted per IDLE handshake.
  - Load_Data changing during SHIFT has no effect, because the hold register is used.
  - Reset mid-SHIFT or mid-CAPTURE: immediate return to IDLE. No Done, Result cleared to 0, Shift_En drops asynchronously. The partial frame is discarded.
- Counter width is clog2(WIDTH). It never wraps, because the exit is on cnt==WIDTH-1.

Optional Feature:
- Macro: SHIFT_SEQ_LOOPBACK_CHECK_EN.
- Defined:
  - At E(W+1), Mismatch <= (Q != expected). Expected is hold when MSB_FIRST=1, bit-reverse(hold) otherwise.
  - Mismatch is a pulse aligned with Done, and is 0 in all other cycles.
- Undefined:
  - The Mismatch port is still present, tied to constant 0.
  - No comparison logic is generated.

Test Plan:
1. Hold Rst_n low for 3 cycles -> Load_Ready=0, Shift_En=0, D=0, Busy=0, Done=0, Result=4'b0000. After release, Load_Ready=1 on the next cycle.
2. WIDTH=4, MSB_FIRST=1, load 4'b1011 with a behavioural shift register -> D=1,0,1,1 on 4 consecutive Shift_En=1 cycles. Done is high exactly 5 edges after the handshake, with Result=4'b1011.
3. Load_Valid held high, Load_Data=4'b0101, then changed to 4'b1100 after the first handshake -> Load_Ready is low for 5 cycles. Second handshake occurs in the Done cycle; Results are 4'b0101 then 4'b1100, and the frames are 6 cycles apart.
4. Load 4'b1111, then pulse Rst_n low after 2 shift edges -> Shift_En drops immediately, no Done, Result=0. A subsequent load of 4'b0110 completes with Result=4'b0110.
5. MSB_FIRST=0, load 4'b0001 -> D sequence 1,0,0,0; Result=4'b1000.
6. SHIFT_SEQ_LOOPBACK_CHECK_EN defined, shift-register model with Q[2] stuck at 0, load 4'b0100 -> Mismatch=1 in the Done cycle. Fault-free model gives Mismatch=0.
